// File: rtl/dmem_burst_reader_if.sv
// dmem_burst_reader_if: groups the command, memory-port and stream signals of
// dmem_burst_reader.
//   command : i_START, i_BASE, i_COUNT -> o_BUSY, o_DONE
//   memory  : o_MEM_ADDR -> i_MEM_RDATA0..7 (words at addr+0..+7, one cycle later)
//   stream  : o_TDATA, o_TVALID, o_TLAST, i_TREADY
// Modport master is the reader itself; slave is the surrounding environment.
interface dmem_burst_reader_if #(
  parameter int data_width = 32,
  parameter int addr_width = 15
);
  logic                  i_START;
  logic [addr_width-1:0] i_BASE;
  logic [addr_width:0]   i_COUNT;
  logic                  o_BUSY;
  logic                  o_DONE;
  logic [addr_width-1:0] o_MEM_ADDR;
  logic [data_width-1:0] i_MEM_RDATA0, i_MEM_RDATA1, i_MEM_RDATA2, i_MEM_RDATA3;
  logic [data_width-1:0] i_MEM_RDATA4, i_MEM_RDATA5, i_MEM_RDATA6, i_MEM_RDATA7;
  logic [data_width-1:0] o_TDATA;
  logic                  o_TVALID;
  logic                  i_TREADY;
  logic                  o_TLAST;

  modport master (
    input  i_START, i_BASE, i_COUNT, i_TREADY,
    input  i_MEM_RDATA0, i_MEM_RDATA1, i_MEM_RDATA2, i_MEM_RDATA3,
    input  i_MEM_RDATA4, i_MEM_RDATA5, i_MEM_RDATA6, i_MEM_RDATA7,
    output o_BUSY, o_DONE, o_MEM_ADDR, o_TDATA, o_TVALID, o_TLAST
  );

  modport slave (
    output i_START, i_BASE, i_COUNT, i_TREADY,
    output i_MEM_RDATA0, i_MEM_RDATA1, i_MEM_RDATA2, i_MEM_RDATA3,
    output i_MEM_RDATA4, i_MEM_RDATA5, i_MEM_RDATA6, i_MEM_RDATA7,
    input  o_BUSY, o_DONE, o_MEM_ADDR, o_TDATA, o_TVALID, o_TLAST
  );
endinterface

// File: rtl/dmem_burst_reader.sv
// dmem_burst_reader: reads i_COUNT words starting at i_BASE from an 8-wide
// synchronous data memory, one line per access, and replays them one word per
// cycle on a valid/ready stream.
//   i_CLK  : clock (shared with the memory read port)
//   i_RSTN : synchronous active-low reset
//   bus    : command, memory-port and stream signals (dmem_burst_reader_if)
// Line flow: ISSUE (memory samples o_MEM_ADDR) -> WAIT (capture n words) ->
// DRAIN (n beats) -> ISSUE of the next line, or FIN when the count is exhausted.
module dmem_burst_reader #(
  parameter int data_width = 32,
  parameter int addr_width = 15
) (
  input  logic                 i_CLK,
  input  logic                 i_RSTN,
  dmem_burst_reader_if.master  bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, FIN} state_t;

  // Number of words in memory, one bit wider than an address.
  localparam logic [addr_width:0] MEM_WORDS = {1'b1, {addr_width{1'b0}}};

  state_t                          state_q, state_d;
  logic [addr_width-1:0]           addr_q;
  logic [addr_width:0]             rem_q;
  logic [3:0]                      n_q;
  logic [2:0]                      idx_q;
  logic [addr_width-1:0]           mem_addr_q;
  logic [7:0][data_width-1:0]      line_q;
  logic [7:0][data_width-1:0]      rdata;

  logic [addr_width:0]             space;
  logic [addr_width:0]             n_lim;
  logic [3:0]                      n_calc;
  logic                            hs;
  logic                            line_end;
  logic [addr_width-1:0]           next_addr;

  assign rdata = {bus.i_MEM_RDATA7, bus.i_MEM_RDATA6, bus.i_MEM_RDATA5, bus.i_MEM_RDATA4,
                  bus.i_MEM_RDATA3, bus.i_MEM_RDATA2, bus.i_MEM_RDATA1, bus.i_MEM_RDATA0};

  // Words left before the top of memory: a line never runs past the last word,
  // so the tail of a wrapping transfer is split into a short line plus a line at 0.
  assign space     = MEM_WORDS - {1'b0, addr_q};
  assign n_lim     = (rem_q < space) ? rem_q : space;
  assign n_calc    = (n_lim < 8) ? n_lim[3:0] : 4'd8;
  assign hs        = (state_q == DRAIN) && bus.i_TREADY;
  assign line_end  = ({1'b0, idx_q} == (n_q - 4'd1));
  assign next_addr = addr_q + addr_width'(n_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_START) state_d = (bus.i_COUNT != '0) ? ISSUE : FIN;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = DRAIN;
      DRAIN:   if (hs && line_end) state_d = (rem_q == 1) ? FIN : ISSUE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      mem_addr_q <= '0;
      line_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.i_START && bus.i_COUNT != '0) begin
          addr_q     <= bus.i_BASE;
          rem_q      <= bus.i_COUNT;
          mem_addr_q <= bus.i_BASE;
        end
        ISSUE: n_q <= n_calc;
        WAIT: begin
          // Only the n valid words are kept; lanes past the line end are dropped.
          for (int k = 0; k < 8; k++)
            if (4'(k) < n_q) line_q[k] <= rdata[k];
          idx_q <= '0;
        end
        DRAIN: if (hs) begin
          idx_q <= idx_q + 3'd1;
          rem_q <= rem_q - 1'b1;
          if (line_end && rem_q != 1) begin
            addr_q     <= next_addr;
            mem_addr_q <= next_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // Stream outputs come straight from registered state, so they hold while stalled.
  assign bus.o_BUSY     = (state_q != IDLE);
  assign bus.o_DONE     = (state_q == FIN);
  assign bus.o_TVALID   = (state_q == DRAIN);
  assign bus.o_TLAST    = (state_q == DRAIN) && (rem_q == 1);
  assign bus.o_TDATA    = (state_q == DRAIN) ? line_q[idx_q] : '0;
  assign bus.o_MEM_ADDR = mem_addr_q;

endmodule

// File: tb/tb_dmem_burst_reader.sv
// tb_dmem_burst_reader: directed transfers against a memory holding mem[a]=a.
// Expected beats are queued when a transfer is started; a negedge monitor pops
// and compares each handshake and checks stall stability.
module tb_dmem_burst_reader;
  localparam int DW = 32;
  localparam int AW = 15;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_burst_reader_if #(.data_width(DW), .addr_width(AW)) bus();
  dmem_burst_reader #(.data_width(DW), .addr_width(AW)) dut (
    .i_CLK (clk),
    .i_RSTN(rst_n),
    .bus   (bus)
  );

  // Memory: word k of the line is address o_MEM_ADDR+k; anything past the top
  // of memory reads as a marker that must never reach the stream.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] base, input int k);
    int a;
    a = int'(base) + k;
    return (a < (1 << AW)) ? DW'(a) : (32'hDEAD_0000 | DW'(k));
  endfunction

  always @(posedge clk) begin
    bus.i_MEM_RDATA0 <= mem_word(bus.o_MEM_ADDR, 0);
    bus.i_MEM_RDATA1 <= mem_word(bus.o_MEM_ADDR, 1);
    bus.i_MEM_RDATA2 <= mem_word(bus.o_MEM_ADDR, 2);
    bus.i_MEM_RDATA3 <= mem_word(bus.o_MEM_ADDR, 3);
    bus.i_MEM_RDATA4 <= mem_word(bus.o_MEM_ADDR, 4);
    bus.i_MEM_RDATA5 <= mem_word(bus.o_MEM_ADDR, 5);
    bus.i_MEM_RDATA6 <= mem_word(bus.o_MEM_ADDR, 6);
    bus.i_MEM_RDATA7 <= mem_word(bus.o_MEM_ADDR, 7);
  end

  int    errors = 0, checks = 0;
  beat_t exp_q[$];
  int    beat_cyc[$];
  int    done_cnt = 0, done_cyc = -1, start_cyc = 0;
  logic  stalled = 1'b0;
  beat_t held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: handshakes pop the scoreboard; a stalled beat must hold next cycle.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) stalled = 1'b0;
    else begin
      if (bus.o_DONE) begin done_cnt++; done_cyc = cyc; end
      if (bus.o_TVALID) begin
        if (stalled) check("stall_hold", {bus.o_TDATA, bus.o_TLAST}, held);
        if (bus.i_TREADY) begin
          beat_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got %0h expected none", bus.o_TDATA);
          end else begin
            e = exp_q.pop_front();
            check("beat", {bus.o_TDATA, bus.o_TLAST}, e);
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {bus.o_TDATA, bus.o_TLAST};
        end
      end else stalled = 1'b0;
    end
  end

  task automatic start_xfer(input int base, input int count);
    beat_t b;
    beat_cyc.delete();
    for (int i = 0; i < count; i++) begin
      b.data = DW'((base + i) % (1 << AW));
      b.last = (i == count - 1);
      exp_q.push_back(b);
    end
    bus.i_START = 1'b1;
    bus.i_BASE  = AW'(base);
    bus.i_COUNT = (AW + 1)'(count);
    @(posedge clk); #1;
    bus.i_START = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_until_done(input string name, input int prev_done, input logic bp);
    int n = 0;
    while (done_cnt == prev_done && n < 300) begin
      @(posedge clk); #1;
      bus.i_TREADY = bp ? (n % 3 == 0) : 1'b1;
      n++;
    end
    bus.i_TREADY = 1'b1;
    if (done_cnt == prev_done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_beats(input int nb);
    int n = 0;
    while (beat_cyc.size() < nb && n < 100) begin @(posedge clk); #1; n++; end
    if (beat_cyc.size() < nb) begin
      checks++; errors++;
      $display("FAIL wait_beats: got %0d beats expected %0d", beat_cyc.size(), nb);
    end
  endtask

  initial begin
    int dc;
    bus.i_START = 1'b0; bus.i_BASE = '0; bus.i_COUNT = '0; bus.i_TREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {bus.o_BUSY, bus.o_DONE, bus.o_TVALID, bus.o_TLAST,
                         bus.o_MEM_ADDR, bus.o_TDATA}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned single line.
    dc = done_cnt;
    start_xfer(16, 8);
    check("t1_mem_addr", bus.o_MEM_ADDR, 16);
    run_until_done("t1", dc, 1'b0);
    check("t1_nbeats", beat_cyc.size(), 8);
    if (beat_cyc.size() == 8) begin
      check("t1_first_lat", beat_cyc[0] - start_cyc, 2);
      check("t1_b2b", beat_cyc[7] - beat_cyc[0], 7);
      check("t1_done_cyc", done_cyc - beat_cyc[7], 1);
    end

    // Two lines: 8 words from 5, then 3 words from 13.
    dc = done_cnt;
    start_xfer(5, 11);
    check("t2_mem_addr0", bus.o_MEM_ADDR, 5);
    run_until_done("t2", dc, 1'b0);
    check("t2_nbeats", beat_cyc.size(), 11);
    if (beat_cyc.size() == 11) check("t2_gap", beat_cyc[8] - beat_cyc[7], 3);
    check("t2_mem_addr1", bus.o_MEM_ADDR, 13);

    // Zero count: straight to FIN, memory address untouched.
    dc = done_cnt;
    start_xfer(100, 0);
    check("t3_mem_addr", bus.o_MEM_ADDR, 13);
    check("t3_busy", bus.o_BUSY, 1);
    run_until_done("t3", dc, 1'b0);
    check("t3_done_cyc", done_cyc - start_cyc, 0);
    check("t3_nbeats", beat_cyc.size(), 0);

    // Backpressure with TREADY 1,0,0 repeating.
    dc = done_cnt;
    start_xfer(0, 8);
    run_until_done("t4", dc, 1'b1);
    check("t4_nbeats", beat_cyc.size(), 8);

    // Wrap across the top of memory.
    dc = done_cnt;
    start_xfer(32766, 4);
    check("t5_mem_addr0", bus.o_MEM_ADDR, 32766);
    run_until_done("t5", dc, 1'b0);
    check("t5_nbeats", beat_cyc.size(), 4);
    check("t5_mem_addr1", bus.o_MEM_ADDR, 0);

    // START while busy is ignored; reset mid-transfer aborts without DONE.
    dc = done_cnt;
    start_xfer(0, 16);
    wait_beats(2);
    bus.i_START = 1'b1; bus.i_BASE = AW'(100); bus.i_COUNT = (AW + 1)'(5);
    @(posedge clk); #1;
    bus.i_START = 1'b0;
    wait_beats(5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_reset_outs", {bus.o_BUSY, bus.o_DONE, bus.o_TVALID, bus.o_TLAST,
                            bus.o_MEM_ADDR, bus.o_TDATA}, 0);
    check("t6_beats_before_rst", beat_cyc.size(), 5);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt, dc);
    start_xfer(16, 8);
    run_until_done("t6b", dc, 1'b0);
    check("t6b_nbeats", beat_cyc.size(), 8);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
